// File: rtl/ul4_seq.sv
// ul4_seq: command FIFO, issue FSM and result capture wrapped around the
// combinational 4-bit logic unit ul4. Commands enter over valid/ready, are
// replayed one at a time onto ul4's a/b/s inputs, and each result is
// registered and offered downstream with a zero flag.
module ul4_seq #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [1:0]       cmd_s,
    input  logic             cmd_acc,
    output logic [WIDTH-1:0] ul_a,
    output logic [WIDTH-1:0] ul_b,
    output logic [1:0]       ul_s,
    input  logic [WIDTH-1:0] ul_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    // entry layout: {acc, s, a, b}
    localparam int EW = 2 * WIDTH + 3;

    typedef enum logic [1:0] {IDLE, EXEC, CAP} state_t;

    state_t            state;
    logic [EW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              push;
    logic              pop;
    logic [EW-1:0]     head;
    logic              head_acc;
    logic [1:0]        head_s;
    logic [WIDTH-1:0]  head_a;
    logic [WIDTH-1:0]  head_b;
    logic [WIDTH-1:0]  acc;

    // Ready comes from the registered count only, so a pop in the same cycle
    // never lets a push into a full FIFO.
    assign cmd_ready = (count != CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (count != '0);

    assign head     = mem[rd_ptr];
    assign head_acc = head[EW-1];
    assign head_s   = head[EW-2 -: 2];
    assign head_a   = head[2*WIDTH-1 -: WIDTH];
    assign head_b   = head[WIDTH-1:0];

    assign res_zero = (res_data == '0);

    // FIFO storage; contents are don't-care while empty, so no reset needed
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {cmd_acc, cmd_s, cmd_a, cmd_b};
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^n
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Issue/capture FSM: IDLE pops onto ul4, EXEC lets it settle, CAP
    // registers the result once the output slot is free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ul_a      <= '0;
            ul_b      <= '0;
            ul_s      <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            acc       <= '0;
        end else begin
            // a consume frees the slot; a capture below in the same cycle wins
            if (res_valid && res_ready)
                res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        // acc is only written in CAP, so a chained command
                        // always sees the previous command's result here
                        ul_a  <= head_acc ? acc : head_a;
                        ul_b  <= head_b;
                        ul_s  <= head_s;
                        state <= EXEC;
                    end
                end
                EXEC: state <= CAP;
                CAP: begin
                    if (!res_valid || res_ready) begin
                        res_data  <= ul_out;
                        acc       <= ul_out;
                        res_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
